emg_sample_sequencer: RTL and testbench
=======================================

// Module: emg_sample_sequencer
// PURPOSE
//   Programmable sample-timebase and channel sequencer for the multi-channel EMG front end.
//   - Divides Clk by a run-time period to produce one-cycle sample ticks.
//   - Steps a channel index round-robin over N_CH channels.
//   - Counts completed frames (one pass over all channels) and runs continuously or for NFrames.
//   - Sits between the control registers and the ADC/mux driver.
// PARAMETERS
//   N_CH       8   number of EMG channels sequenced, >=1, need not be a power of two
//   CH_BITS    3   width of Ch, >= clog2(N_CH)
//   DIV_BITS   8   width of Period and of the internal divider counter
//   FRAME_BITS 8   width of NFrames and of the internal frame counter
// PORTS
//   Clk         in   1           clock
//   Reset       in   1           synchronous, active-high reset
//   Start       in   1           pulse: begin a run; sampled only in IDLE
//   Stop        in   1           pulse: abort a run immediately
//   Period      in   DIV_BITS    tick spacing minus 1; latched at Start
//   NFrames     in   FRAME_BITS  frames per run, 0 = continuous; latched at Start
//   Busy        out  1           high while state is RUN
//   Tick        out  1           one-cycle sample strobe
//   Ch          out  CH_BITS     channel the current/next Tick belongs to
//   Frame_Done  out  1           one-cycle pulse coincident with the Tick of channel N_CH-1
//   Done        out  1           one-cycle pulse when a finite run completes
// BEHAVIOUR
//   - Reset, synchronous on Clk:
//     - all outputs 0 and state IDLE.
//     - divider, frame counter and Ch cleared.
//     - Reset overrides every other input on the same edge, including mid-run.
//   - Outputs are registered; no combinational input-to-output path.
//   - FSM IDLE -> RUN -> DONE -> IDLE:
//     - IDLE: Start=1 and Stop=0 -> RUN. On that edge:
//       - latch Period and NFrames.
//       - div=0, Ch=0, frame count=0, Busy=1.
//     - IDLE: Start and Stop both 1 -> stay in IDLE.
//     - RUN, divider:
//       - div increments each cycle.
//       - At div==Period: div<=0 and Tick<=1 for the next cycle.
//       - Start at edge k gives the first Tick in cycle k+Period+1.
//       - Ticks are then every Period+1 cycles.
//       - Period=0 gives a Tick every cycle.
//     - RUN, channel stepping:
//       - Ch stays stable through each Tick cycle.
//       - Ch advances on the edge ending the Tick.
//       - Ch wraps from N_CH-1 to 0.
//       - Frame_Done is asserted together with the Tick on Ch==N_CH-1.
//       - The frame counter increments on that Tick.
//       - N_CH=1: every Tick is also a Frame_Done.
//     - RUN, end of run:
//       - NFrames!=0 and the frame counter reaches NFrames -> DONE on the edge ending that Tick.
//       - NFrames=0 -> never ends; the frame counter wraps silently.
//     - RUN, Stop=1:
//       - -> IDLE on that edge, with Busy=0 and Ch=0.
//       - No Done, and any Tick pending for the next cycle is suppressed.
//       - Start is ignored while in RUN.
//     - DONE: Done=1 and Busy=0 for exactly one cycle, then -> IDLE.
//       - Start in DONE is ignored.
//   - Changing Period or NFrames during RUN has no effect until the next Start.
//   - All counters are unsigned with modulo-2^width wrap; the divider compare is equality only.
// CONFIGURATION
//   - Macro EMG_SEQ_FRAME_CNT_EN:
//     - Defined: adds output port Frame_Count [FRAME_BITS-1:0] carrying the live frame counter.
//       - Reset value 0; cleared at Start.
//       - Updates on the edge ending each Frame_Done.
//       - Holds its value in IDLE and DONE for software readback.
//     - Undefined: the port is absent; the frame counter remains internal; all other behaviour is identical.
// STRUCTURE
//   - Package emg_seq_pkg:
//     - state enum {IDLE, RUN, DONE}.
//     - a clog2 constant function for CH_BITS sanity checking.
//     - default widths.
//   - Sub-module emg_tick_divider: DIV_BITS counter with clear, enable, period input and one-cycle tick output.
//   - The top level holds the FSM, the channel counter and the frame counter.
// TESTING
//   - Reset during RUN: Reset -> all outputs 0 next cycle and no further Tick until a new Start.
//   - Period=3, N_CH=8, NFrames=1:
//     - Ticks 4 cycles apart with Ch 0..7.
//     - Frame_Done on the Ch=7 Tick.
//     - Done 1 cycle later; Busy low from Done.
//   - Period=0, N_CH=5, NFrames=2:
//     - Tick every cycle with Ch 0,1,2,3,4,0,1,2,3,4.
//     - Two Frame_Done pulses, then Done.
//   - NFrames=0, Period=1: runs over 300 frames.
//     - The frame counter wraps with no Done.
//     - Stop mid-divider -> Busy=0 next cycle, no Tick, no Done.
//   - Start and Stop together in IDLE:
//     - The design stays in IDLE.
//     - A later Start while in RUN is ignored; the Tick timing is unchanged.
//   - EMG_SEQ_FRAME_CNT_EN defined, NFrames=3: Frame_Count steps 1,2,3 and holds 3 in IDLE.

Source files
------------

// File: rtl/emg_sample_sequencer_pkg.sv
// Shared types, default widths and helpers for the EMG sample sequencer.
// Optional feature macro used by this block: EMG_SEQ_FRAME_CNT_EN (see interface and top).
package emg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int DEF_N_CH       = 8;
  localparam int DEF_CH_BITS    = 3;
  localparam int DEF_DIV_BITS   = 8;
  localparam int DEF_FRAME_BITS = 8;

  // Bits needed to index 'value' distinct items; 0 for a single item.
  function automatic int emg_clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/emg_sample_sequencer_if.sv
// Control/status bundle between the register block (master) and the sequencer (slave).
// Frame_Count exists only when EMG_SEQ_FRAME_CNT_EN is defined.
interface emg_sample_sequencer_if
  import emg_seq_pkg::*;
#(
  parameter int CH_BITS    = DEF_CH_BITS,
  parameter int DIV_BITS   = DEF_DIV_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS
);

  logic                  Start;
  logic                  Stop;
  logic [DIV_BITS-1:0]   Period;
  logic [FRAME_BITS-1:0] NFrames;
  logic                  Busy;
  logic                  Tick;
  logic [CH_BITS-1:0]    Ch;
  logic                  Frame_Done;
  logic                  Done;

`ifdef EMG_SEQ_FRAME_CNT_EN
  logic [FRAME_BITS-1:0] Frame_Count;

  modport master (
    output Start, Stop, Period, NFrames,
    input  Busy, Tick, Ch, Frame_Done, Done, Frame_Count
  );

  modport slave (
    input  Start, Stop, Period, NFrames,
    output Busy, Tick, Ch, Frame_Done, Done, Frame_Count
  );
`else
  modport master (
    output Start, Stop, Period, NFrames,
    input  Busy, Tick, Ch, Frame_Done, Done
  );

  modport slave (
    input  Start, Stop, Period, NFrames,
    output Busy, Tick, Ch, Frame_Done, Done
  );
`endif

endinterface

// File: rtl/emg_sample_sequencer_tick_divider.sv
// Programmable clock divider: Tick_o flags the cycle in which the count reaches Period_i.
module emg_tick_divider #(
  parameter int DIV_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Clear_i,
  input  logic                Enable_i,
  input  logic [DIV_BITS-1:0] Period_i,
  output logic                Tick_o
);

  logic [DIV_BITS-1:0] cnt_q;

  assign Tick_o = Enable_i && (cnt_q == Period_i);

  always_ff @(posedge Clk) begin
    if (Reset || Clear_i) begin
      cnt_q <= '0;
    end else if (Enable_i) begin
      cnt_q <= Tick_o ? '0 : cnt_q + DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/emg_sample_sequencer.sv
// Sample timebase and round-robin channel sequencer for the EMG front end.
// Define EMG_SEQ_FRAME_CNT_EN to export the live frame counter as Frame_Count.
module emg_sample_sequencer
  import emg_seq_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CH_BITS    = DEF_CH_BITS,
  parameter int DIV_BITS   = DEF_DIV_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input logic                   Clk,
  input logic                   Reset,
  emg_sample_sequencer_if.slave bus
);

  if (CH_BITS < emg_clog2(N_CH)) begin : gChBitsCheck
    $error("emg_sample_sequencer: CH_BITS too narrow for N_CH");
  end

  seq_state_e            state_q;
  logic [DIV_BITS-1:0]   period_q;
  logic [FRAME_BITS-1:0] nFrames_q;
  logic [FRAME_BITS-1:0] frameCnt_q;
  logic [CH_BITS-1:0]    ch_q;
  logic                  busy_q;
  logic                  tick_q;
  logic                  frameDone_q;
  logic                  done_q;

  logic                  divTick;
  logic                  divClear_d;
  logic                  startAcc_d;
  logic                  endRun_d;
  logic                  tickNext_d;
  logic [CH_BITS-1:0]    chStep_d;
  logic [CH_BITS-1:0]    chNext_d;

  // chNext_d is the channel owned by the cycle after this edge; with Period=0
  // a Tick can end and the next one begin on the same edge.
  always_comb begin
    startAcc_d = (state_q == IDLE) && bus.Start && !bus.Stop;
    divClear_d = startAcc_d || ((state_q == RUN) && bus.Stop);
    chStep_d   = (ch_q == CH_BITS'(N_CH - 1)) ? '0 : ch_q + CH_BITS'(1);
    chNext_d   = tick_q ? chStep_d : ch_q;
    endRun_d   = tick_q && frameDone_q && (nFrames_q != '0) &&
                 ((frameCnt_q + FRAME_BITS'(1)) == nFrames_q);
    tickNext_d = (state_q == RUN) && !bus.Stop && !endRun_d && divTick;
  end

  emg_tick_divider #(
    .DIV_BITS (DIV_BITS)
  ) uDivider (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear_i  (divClear_d),
    .Enable_i (state_q == RUN),
    .Period_i (period_q),
    .Tick_o   (divTick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      period_q    <= '0;
      nFrames_q   <= '0;
      frameCnt_q  <= '0;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      frameDone_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tick_q      <= 1'b0;
      frameDone_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAcc_d) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            period_q   <= bus.Period;
            nFrames_q  <= bus.NFrames;
            frameCnt_q <= '0;
            ch_q       <= '0;
          end
        end
        RUN: begin
          if (bus.Stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ch_q    <= '0;
          end else begin
            tick_q      <= tickNext_d;
            frameDone_q <= tickNext_d && (chNext_d == CH_BITS'(N_CH - 1));
            ch_q        <= chNext_d;
            if (tick_q && frameDone_q) begin
              frameCnt_q <= frameCnt_q + FRAME_BITS'(1);
            end
            if (endRun_d) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy       = busy_q;
  assign bus.Tick       = tick_q;
  assign bus.Ch         = ch_q;
  assign bus.Frame_Done = frameDone_q;
  assign bus.Done       = done_q;

`ifdef EMG_SEQ_FRAME_CNT_EN
  assign bus.Frame_Count = frameCnt_q;
`else
`endif

endmodule

// File: tb/tb_emg_sample_sequencer.sv
// Self-checking bench: two sequencers (8 and 5 channels) share stimulus and are
// compared every cycle against a closed-form schedule model of each run.
module tb_emg_sample_sequencer;

  logic Clk;
  logic Reset;

  emg_sample_sequencer_if #(.CH_BITS(3), .DIV_BITS(8), .FRAME_BITS(8)) bus8 ();
  emg_sample_sequencer_if #(.CH_BITS(3), .DIV_BITS(8), .FRAME_BITS(8)) bus5 ();

  emg_sample_sequencer #(
    .N_CH(8), .CH_BITS(3), .DIV_BITS(8), .FRAME_BITS(8)
  ) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8)
  );

  emg_sample_sequencer #(
    .N_CH(5), .CH_BITS(3), .DIV_BITS(8), .FRAME_BITS(8)
  ) dut5 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus5)
  );

  int cyc;
  int checkCount;
  int passCount;

  // Per-DUT run record: a run is described by its start edge, latched
  // Period/NFrames, and the edge at which it was stopped (if any).
  int mN[2];
  bit mStarted[2];
  bit mStopped[2];
  int mStart[2];
  int mP[2];
  int mF[2];
  int mDoneCyc[2];
  int mStopEdge[2];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
  endtask

  function automatic bit runningIn(input int d, input int c);
    if (!mStarted[d]) return 1'b0;
    if (mStopped[d] && c >= mStopEdge[d]) return 1'b0;
    if (mF[d] != 0 && c >= mDoneCyc[d]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit idleIn(input int d, input int c);
    if (!mStarted[d]) return 1'b1;
    if (mStopped[d] && c >= mStopEdge[d]) return 1'b1;
    if (mF[d] != 0 && c > mDoneCyc[d]) return 1'b1;
    return 1'b0;
  endfunction

  // Cycle c is the interval after clock edge c. Tick number i (1-based) of a
  // run started at edge s falls in cycle s + i*(P+1) and owns channel (i-1) mod N.
  function automatic void predict(input int d, input int c,
                                  output int busy, output int tick, output int ch,
                                  output int fd, output int done, output int fc);
    int t;
    int n;
    busy = 0; tick = 0; ch = 0; fd = 0; done = 0; fc = 0;
    if (!mStarted[d]) return;
    if (mStopped[d] && c >= mStopEdge[d]) begin
      fc = -1;
      return;
    end
    if (mF[d] != 0 && c >= mDoneCyc[d]) begin
      done = (c == mDoneCyc[d]) ? 1 : 0;
      fc   = mF[d] % 256;
      return;
    end
    t    = c - mStart[d];
    n    = (t == 0) ? 0 : (t - 1) / (mP[d] + 1);
    busy = 1;
    ch   = n % mN[d];
    tick = (t >= 1 && (t % (mP[d] + 1)) == 0) ? 1 : 0;
    fd   = (tick == 1 && ch == mN[d] - 1) ? 1 : 0;
    fc   = (n / mN[d]) % 256;
  endfunction

  task automatic modelEdge(input int e, input bit start, input bit stop, input bit rst,
                           input int p, input int f);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mStarted[d] = 1'b0;
        mStopped[d] = 1'b0;
      end else if (runningIn(d, e - 1) && stop) begin
        mStopped[d]  = 1'b1;
        mStopEdge[d] = e;
      end else if (idleIn(d, e - 1) && start && !stop) begin
        mStarted[d] = 1'b1;
        mStopped[d] = 1'b0;
        mStart[d]   = e;
        mP[d]       = p;
        mF[d]       = f;
        mDoneCyc[d] = e + (p + 1) * f * mN[d] + 1;
      end
    end
  endtask

  task automatic checkAll();
    int eBusy, eTick, eCh, eFd, eDone, eFc;
    int oBusy, oTick, oCh, oFd, oDone, oFc;
    for (int d = 0; d < 2; d++) begin
      predict(d, cyc, eBusy, eTick, eCh, eFd, eDone, eFc);
      if (d == 0) begin
        oBusy = int'(bus8.Busy); oTick = int'(bus8.Tick); oCh = int'(bus8.Ch);
        oFd = int'(bus8.Frame_Done); oDone = int'(bus8.Done);
`ifdef EMG_SEQ_FRAME_CNT_EN
        oFc = int'(bus8.Frame_Count);
`else
        oFc = 0;
`endif
      end else begin
        oBusy = int'(bus5.Busy); oTick = int'(bus5.Tick); oCh = int'(bus5.Ch);
        oFd = int'(bus5.Frame_Done); oDone = int'(bus5.Done);
`ifdef EMG_SEQ_FRAME_CNT_EN
        oFc = int'(bus5.Frame_Count);
`else
        oFc = 0;
`endif
      end
      checkOutput($sformatf("n%0d.Busy@%0d", mN[d], cyc), oBusy, eBusy);
      checkOutput($sformatf("n%0d.Tick@%0d", mN[d], cyc), oTick, eTick);
      checkOutput($sformatf("n%0d.Ch@%0d", mN[d], cyc), oCh, eCh);
      checkOutput($sformatf("n%0d.Frame_Done@%0d", mN[d], cyc), oFd, eFd);
      checkOutput($sformatf("n%0d.Done@%0d", mN[d], cyc), oDone, eDone);
`ifdef EMG_SEQ_FRAME_CNT_EN
      if (eFc >= 0) checkOutput($sformatf("n%0d.Frame_Count@%0d", mN[d], cyc), oFc, eFc);
`endif
    end
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit rst,
                               input int p, input int f);
    Reset        = rst;
    bus8.Start   = start;  bus5.Start   = start;
    bus8.Stop    = stop;   bus5.Stop    = stop;
    bus8.Period  = 8'(p);  bus5.Period  = 8'(p);
    bus8.NFrames = 8'(f);  bus5.NFrames = 8'(f);
    modelEdge(cyc + 1, start, stop, rst, p, f);
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    checkAll();
  endtask

  // Idle cycles keep Period/NFrames moving so that latching at Start is exercised.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    int eBusy, eTick, eCh, eFd, eDone, eFc;
    cyc = 0;
    checkCount = 0;
    passCount = 0;
    mN = '{8, 5};
    mStarted = '{1'b0, 1'b0};
    mStopped = '{1'b0, 1'b0};
    mStart = '{0, 0}; mP = '{0, 0}; mF = '{0, 0};
    mDoneCyc = '{0, 0}; mStopEdge = '{0, 0};
    Reset = 1'b1;
    bus8.Start = 1'b0; bus8.Stop = 1'b0; bus8.Period = '0; bus8.NFrames = '0;
    bus5.Start = 1'b0; bus5.Stop = 1'b0; bus5.Period = '0; bus5.NFrames = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    idleCycles(2);

    $display("[TB] Period=3 NFrames=1");
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 1);
    idleCycles(40);

    $display("[TB] Period=0 NFrames=2");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 2);
    idleCycles(20);

    $display("[TB] reset during run");
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 0);
    idleCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 0);
    idleCycles(12);

    $display("[TB] continuous run, Period=1, then Stop mid-divider");
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 0);
    idleCycles(4810);
    predict(0, cyc, eBusy, eTick, eCh, eFd, eDone, eFc);
    if (eTick != 0) idleCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 0);
    idleCycles(6);

    $display("[TB] Start with Stop in IDLE, then Start during RUN");
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 1);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 1);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    idleCycles(30);

    $display("[TB] Period=1 NFrames=3");
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 3);
    idleCycles(60);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 255) == 0,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    idleCycles(40);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
